// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1-miss memory-port arbiter: FSM state, grant owner
// and the cacheline offset width used to align addresses.
package cache_arbiter_pkg;

    localparam int LINE_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one cacheline-adaptor port between the I-cache fill path and the
// D-cache fill/writeback path; one transaction at a time, round-robin on ties.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_read,
    input  logic [ADDR_WIDTH-1:0] imem_address,
    output logic [LINE_WIDTH-1:0] imem_rdata,
    output logic                  imem_resp,
    input  logic                  dmem_read,
    input  logic                  dmem_write,
    input  logic [ADDR_WIDTH-1:0] dmem_address,
    input  logic [LINE_WIDTH-1:0] dmem_wdata,
    output logic [LINE_WIDTH-1:0] dmem_rdata,
    output logic                  dmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
        {{(ADDR_WIDTH-LINE_OFFSET_BITS){1'b0}}, {LINE_OFFSET_BITS{1'b1}}};

    arb_state_t state, state_next;
    arb_grant_t last_grant, last_grant_next;
    logic       lat_read, lat_write;
    logic       i_req, d_req;

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~OFFSET_MASK;
    endfunction

    assign i_req = imem_read;
    assign d_req = dmem_read | dmem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            lat_read   <= 1'b0;
            lat_write  <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            // Request kind is frozen at grant so a dropped request cannot change the bus op mid-flight
            if (state == IDLE && state_next == SERVE_D) begin
                lat_read  <= dmem_read;
                lat_write <= dmem_write;
            end
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || last_grant == GRANT_D)) begin
                    state_next      = SERVE_I;
                    last_grant_next = GRANT_I;
                end else if (d_req) begin
                    state_next      = SERVE_D;
                    last_grant_next = GRANT_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        imem_resp    = 1'b0;
        imem_rdata   = '0;
        dmem_resp    = 1'b0;
        dmem_rdata   = '0;
        if (!rst) begin
            case (state)
                SERVE_I: begin
                    pmem_read    = 1'b1;
                    pmem_address = line_align(imem_address);
                    imem_resp    = pmem_resp;
                    imem_rdata   = pmem_resp ? pmem_rdata : '0;
                end
                SERVE_D: begin
                    pmem_write   = lat_write;
                    pmem_read    = lat_read & ~lat_write;
                    pmem_address = line_align(dmem_address);
                    pmem_wdata   = dmem_wdata;
                    dmem_resp    = pmem_resp;
                    dmem_rdata   = pmem_resp ? pmem_rdata : '0;
                end
                default: ;
            endcase
        end
    end

endmodule
